present_ctrl: RTL
=================

# present_ctrl

Two-port request scheduler and sequencer for the 80-bit-key PRESENT encoder core. It arbitrates round-robin between two requesters and drives the core's two-step load: key first, then plaintext. It waits out the 31 round cycles, captures the ciphertext while the core's `done` is high, and returns it on a valid/ready response channel. It sits between the bus-facing request logic and the encoder; only this block drives the encoder's `pl`/`in_text`.

## Interface
- `TIMEOUT`, 40: RUN-state cycle limit; used only when the watchdog is compiled in.

- `clk` in 1: single clock, rising edge.
- `n_reset` in 1: asynchronous, active-low reset.
- `req_valid` in 2: per-port request valid; must hold with stable data until ready.
- `req_key` in 2×80 (`req_key0`, `req_key1`): per-port 80-bit key.
- `req_pt` in 2×64 (`req_pt0`, `req_pt1`): per-port plaintext.
- `req_ready` out 2: per-port accept, one-hot or zero.
- `rsp_valid` out 1: response valid.
- `rsp_ready` in 1: response consumer ready.
- `rsp_id` out 1: port that issued the response.
- `rsp_ct` out 64: ciphertext.
- `rsp_err` out 1: watchdog expiry flag; 0 when the watchdog is compiled out.
- `enc_pl` out 2: to encoder `pl`. `10` loads the key, `01` loads the word and starts the rounds.
- `enc_in_text` out 80: to encoder `in_text`.
- `enc_done` in 1: from encoder `done`.
- `enc_ct` in 64: from encoder `ciphertext`. Valid only while `enc_done`=1; high-Z otherwise.

## Operation
- FSM states are IDLE, LOAD_KEY, LOAD_PT, RUN, RESP. Reset state is IDLE.
- **IDLE, arbitration:**
  - If exactly one `req_valid` bit is set, that port is granted.
  - If both are set, the port not granted last wins.
  - The last-grant pointer resets to port 1, so port 0 wins the first tie.
  - `req_ready[i]` = (state==IDLE) & grant[i] & `n_reset`.
- **IDLE, on handshake:**
  - Latch key, plaintext and id.
  - Update the pointer.
  - Go to LOAD_KEY.
- **LOAD_KEY:**
  - `enc_pl`=10; `enc_in_text`=latched key.
  - Next state is LOAD_PT.
  - Key and word are never loaded in the same cycle because they share `in_text`.
  - The key is reloaded on every request because the core mutates its key register during the rounds.
- **LOAD_PT:**
  - `enc_pl`=01; `enc_in_text`={16'h0, latched plaintext}.
  - Next state is RUN.
- **RUN:**
  - `enc_pl`=00; `enc_in_text`=0.
  - When `enc_done`=1, capture `enc_ct` into `rsp_ct`, set `rsp_err`=0, go to RESP.
  - `enc_ct` is sampled only when `enc_done`=1, never while it is high-Z.
- **RESP:**
  - `rsp_valid`=1; `rsp_ct`, `rsp_id` and `rsp_err` are held stable.
  - On `rsp_valid & rsp_ready`, go to IDLE.
  - A new accept happens no earlier than the cycle after the response handshake.
- **Outputs in every state:**
  - `enc_pl` and `req_ready` are decoded combinationally from state.
  - All other outputs are registered.
- **Reset values:**
  - `rsp_valid`=0, `rsp_id`=0, `rsp_ct`=0, `rsp_err`=0.
  - `enc_pl`=00, `enc_in_text`=0, `req_ready`=00.
- **Reset mid-operation:**
  - The in-flight request is dropped with no response.
  - A requester whose `req_valid` is still high is re-arbitrated after reset.
  - The encoder shares `n_reset`, so the two stay consistent.

## Timing
Cycle numbering is relative to accept edge E0.
- E1: key loaded.
- E2: word loaded; encoder counter=1.
- E33: encoder counter=32; `enc_done` rises.
- E34: `rsp_ct` captured; `rsp_valid`=1.
- Accept-to-`rsp_valid` latency is exactly 34 cycles.
- With `rsp_ready` held high, the handshake completes at E35, IDLE holds at E36, and the next accept is at E36.
- Minimum request-to-request interval is 36 cycles.
- `enc_done` may already be high during LOAD_KEY, left over from the prior operation. It is ignored outside RUN.

## Configuration
- **`PRESENT_CTRL_WATCHDOG_EN` defined:**
  - A 6-bit RUN-cycle counter clears on entry to RUN.
  - If it reaches `TIMEOUT` with `enc_done`=0, go to RESP with `rsp_err`=1 and `rsp_ct`=0.
  - If `enc_done`=1 in the same cycle the counter reaches `TIMEOUT`, done wins and `rsp_err`=0.
- **Macro undefined:**
  - No counter is built; RUN waits indefinitely.
  - `rsp_err` is tied to 0.
  - `TIMEOUT` is unused.

## Test plan
- Port 0, key=0, pt=0 → `rsp_ct`=5579c1387b228445, `rsp_id`=0, `rsp_valid` at E34.
- Port 1, key=FFFF…FF (80-bit), pt=0 → e72c46c0f5945049. Then key=0, pt=FFFF…FF → a112ffc72f68417b, proving the key reload. Then key=FF…FF, pt=FF…FF → 3333dcd3213210d2.
- Both ports valid continuously → grants alternate 0,1,0,1; each port gets exactly one `req_ready` pulse per response.
- `rsp_ready` low for 5 cycles after `rsp_valid` → `rsp_ct`/`rsp_id` stable; `req_ready`=00 throughout; accept 1 cycle after the handshake.
- `n_reset` pulsed at E20 → all outputs at reset values; no response; the still-valid request is re-accepted and completes with correct ciphertext.
- Watchdog build, encoder replaced by a stub holding `enc_done`=0 → `rsp_valid`, `rsp_err`=1, `rsp_ct`=0 at E2+`TIMEOUT`+1. Stub asserting `enc_done` on the timeout cycle → `rsp_err`=0.

Source files
------------

// File: rtl/present_ctrl_if.sv
// Request/response bundle between the bus-facing requesters and present_ctrl.
// The master modport is the requester/consumer side, slave is the controller.
interface present_ctrl_if;
    logic [1:0]  req_valid;
    logic [79:0] req_key0;
    logic [79:0] req_key1;
    logic [63:0] req_pt0;
    logic [63:0] req_pt1;
    logic [1:0]  req_ready;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [63:0] rsp_ct;
    logic        rsp_err;

    modport master (
        output req_valid, req_key0, req_key1, req_pt0, req_pt1, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_ct, rsp_err
    );

    modport slave (
        input  req_valid, req_key0, req_key1, req_pt0, req_pt1, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_ct, rsp_err
    );
endinterface

// File: rtl/present_ctrl.sv
// Two-port round-robin scheduler and key/plaintext load sequencer for a PRESENT-80 encoder.
// Optional RUN-state watchdog: define PRESENT_CTRL_WATCHDOG_EN.
module present_ctrl #(
    parameter int unsigned TIMEOUT = 40
) (
    input  logic          clk,
    input  logic          n_reset,
    present_ctrl_if.slave bus,
    output logic [1:0]    enc_pl,
    output logic [79:0]   enc_in_text,
    input  logic          enc_done,
    input  logic [63:0]   enc_ct
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_KEY,
        LOAD_PT,
        RUN,
        RESP
    } state_t;

    state_t      state_q, state_d;
    logic        last_q, last_d;
    logic [63:0] pt_q, pt_d;
    logic [79:0] text_q, text_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_id_q, rsp_id_d;
    logic [63:0] rsp_ct_q, rsp_ct_d;
    logic [1:0]  grant;
    logic        accept;
    logic        sel;

    // Tie goes to the port that was not granted last.
    always_comb begin
        grant[0] = bus.req_valid[0] & (~bus.req_valid[1] | last_q);
        grant[1] = bus.req_valid[1] & (~bus.req_valid[0] | ~last_q);
    end

    assign bus.req_ready = (state_q == IDLE && n_reset) ? grant : 2'b00;
    assign accept        = |bus.req_ready;
    assign sel           = grant[1];

    always_comb begin
        enc_pl = 2'b00;
        case (state_q)
            LOAD_KEY: enc_pl = 2'b10;
            LOAD_PT:  enc_pl = 2'b01;
            default:  enc_pl = 2'b00;
        endcase
    end

`ifdef PRESENT_CTRL_WATCHDOG_EN
    logic [5:0] wd_q, wd_d;
    logic       rsp_err_q, rsp_err_d;
`endif

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        pt_d        = pt_q;
        text_d      = '0;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_ct_d    = rsp_ct_q;
`ifdef PRESENT_CTRL_WATCHDOG_EN
        wd_d        = wd_q;
        rsp_err_d   = rsp_err_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d  = LOAD_KEY;
                    last_d   = sel;
                    rsp_id_d = sel;
                    pt_d     = sel ? bus.req_pt1 : bus.req_pt0;
                    text_d   = sel ? bus.req_key1 : bus.req_key0;
                end
            end
            LOAD_KEY: begin
                state_d = LOAD_PT;
                text_d  = {16'h0, pt_q};
            end
            LOAD_PT: begin
                state_d = RUN;
`ifdef PRESENT_CTRL_WATCHDOG_EN
                wd_d    = '0;
`endif
            end
            RUN: begin
                // enc_ct is only meaningful while enc_done is high
                if (enc_done) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_ct_d    = enc_ct;
`ifdef PRESENT_CTRL_WATCHDOG_EN
                    rsp_err_d   = 1'b0;
                end else if (wd_q == 6'(TIMEOUT)) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_ct_d    = '0;
                    rsp_err_d   = 1'b1;
                end else begin
                    wd_d        = wd_q + 6'd1;
`endif
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            pt_q        <= '0;
            text_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_ct_q    <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            pt_q        <= pt_d;
            text_q      <= text_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_ct_q    <= rsp_ct_d;
        end
    end

`ifdef PRESENT_CTRL_WATCHDOG_EN
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            wd_q      <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            wd_q      <= wd_d;
            rsp_err_q <= rsp_err_d;
        end
    end

    assign bus.rsp_err = rsp_err_q;
`else
    assign bus.rsp_err = 1'b0;
`endif

    assign enc_in_text   = text_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_ct    = rsp_ct_q;

endmodule
